// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared widths, register index constants and typedefs for the MIPS core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_decoder.sv
// ============================================================================
// Module : regfile_wr_decoder
// Brief  : we + wr_addr -> one-hot register write-enable vector, bit 0 never set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wr_decoder #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic [2**ADDR_W-1:0] wr_sel
);

  always_comb begin
    wr_sel = '0;
    if (we && (wr_addr != ADDR_W'(mips_pkg::REG_ZERO))) begin
      wr_sel[wr_addr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_regfile.sv
// ============================================================================
// Module : mips_regfile
// Brief  : 32x32 MIPS register file, one decoded write port, two async read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  import mips_pkg::*;

  localparam int c_depth = 2**ADDR_W;

  logic [c_depth-1:0] w_wr_sel;
  logic [DATA_W-1:0]  w_words [c_depth];
  logic [DATA_W-1:0]  w_stored_a;
  logic [DATA_W-1:0]  w_stored_b;
  logic               w_hit_a;
  logic               w_hit_b;

  regfile_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .we      (we),
    .wr_addr (wr_addr),
    .wr_sel  (w_wr_sel)
  );

  // $zero has no storage at all; it is a constant leg of the read muxes.
  assign w_words[REG_ZERO] = '0;

  for (genvar k = 1; k < c_depth; k++) begin : g_reg
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (w_wr_sel[k]) begin
        r_word <= wr_data;
      end
    end

    assign w_words[k] = r_word;
  end

  assign w_stored_a = w_words[rd_addr_a];
  assign w_stored_b = w_words[rd_addr_b];

  // The decoder already excludes index 0 and we=0, so its bit doubles as the hit flag.
  if (BYPASS != 0) begin : g_bypass
    assign w_hit_a = w_wr_sel[rd_addr_a];
    assign w_hit_b = w_wr_sel[rd_addr_b];
  end else begin : g_no_bypass
    assign w_hit_a = 1'b0;
    assign w_hit_b = 1'b0;
  end

  // Outputs are forced low during reset so a bypassed write cannot leak through.
  assign rd_data_a = !rst_n ? '0 : (w_hit_a ? wr_data : w_stored_a);
  assign rd_data_b = !rst_n ? '0 : (w_hit_b ? wr_data : w_stored_b);

endmodule

`default_nettype wire

// File: tb/tb_mips_regfile.sv
// ============================================================================
// Module : tb_mips_regfile
// Brief  : Self-checking bench driving BYPASS=1 and BYPASS=0 register files side by side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] a_byp, b_byp, a_nob, b_nob;

  int          n_cmp;
  int          n_err;
  logic [31:0] model [32];
  logic [127:0] obs, expv;

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a_byp), .rd_data_b(b_byp)
  );

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nob (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a_nob), .rd_data_b(b_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of a read: reset and $zero give 0, a live write forwards if bypassing.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (!rst_n || ra == 5'd0) return 32'd0;
    if (byp && we && (wr_addr == ra)) return wr_data;
    return model[ra];
  endfunction

  function automatic logic [127:0] exp_all();
    return {exp_rd(rd_addr_a, 1'b1), exp_rd(rd_addr_b, 1'b1),
            exp_rd(rd_addr_a, 1'b0), exp_rd(rd_addr_b, 1'b0)};
  endfunction

  // Advance one clock; leaves time at negedge+1 so the next stimulus is far from posedge.
  task automatic step();
    @(posedge clk);
    if (rst_n && we && (wr_addr != 5'd0)) model[wr_addr] = wr_data;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    we = w; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #0.1;
      n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
      if (obs !== expv) begin n_err++; $display("FAIL reset_read idx=%0d got=%h want=%h", i, obs, expv); end
    end
    drive(1'b1, 5'd8, 32'd1111, 5'd8, 5'd8);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
    if (obs !== expv) begin n_err++; $display("FAIL reset_bypass_blocked got=%h want=%h", obs, expv); end
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd8, 32'd0, 5'd8, 5'd8);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
    if (obs !== expv) begin n_err++; $display("FAIL reset_write_lost got=%h want=%h", obs, expv); end
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd8, 32'd1111, 5'd1, 5'd2); step();
    drive(1'b1, 5'd9, 32'd9999, 5'd1, 5'd2); step();
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob};
    expv = {32'd1111, 32'd9999, 32'd1111, 32'd9999};
    if (obs !== expv) begin n_err++; $display("FAIL basic_rw got=%h want=%h", obs, expv); end
  endtask

  task automatic test_zero();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
    if (obs !== expv) begin n_err++; $display("FAIL zero_same_cycle got=%h want=%h", obs, expv); end
    step();
    drive(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
    if (obs !== expv) begin n_err++; $display("FAIL zero_after_write got=%h want=%h", obs, expv); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd31, 32'h0000_0004, 5'd0, 5'd0); step();
    drive(1'b1, 5'd31, 32'h0040_0010, 5'd31, 5'd31);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob};
    expv = {32'h0040_0010, 32'h0040_0010, 32'h0000_0004, 32'h0000_0004};
    if (obs !== expv) begin n_err++; $display("FAIL bypass_before_edge got=%h want=%h", obs, expv); end
    step();
    drive(1'b0, 5'd31, 32'h0, 5'd31, 5'd31);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = {4{32'h0040_0010}};
    if (obs !== expv) begin n_err++; $display("FAIL bypass_after_edge got=%h want=%h", obs, expv); end
  endtask

  task automatic test_fill_isolation();
    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 5'(k), 32'(k * 3), 5'd0, 5'd0); step();
    end
    drive(1'b0, 5'd5, 32'd0, 5'd0, 5'd0); step();
    for (int k = 0; k < 32; k++) begin
      rd_addr_a = 5'(k); rd_addr_b = 5'(31 - k);
      #0.1;
      n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob};
      expv = {32'(k * 3), 32'((31 - k) * 3), 32'(k * 3), 32'((31 - k) * 3)};
      if (obs !== expv) begin n_err++; $display("FAIL fill_sweep idx=%0d got=%h want=%h", k, obs, expv); end
    end
  endtask

  task automatic test_random();
    logic [4:0] wa;
    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom), wa, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = exp_all();
      if (obs !== expv) begin
        n_err++;
        $display("FAIL random i=%0d we=%0d wa=%0d ra=%0d rb=%0d got=%h want=%h",
                 i, we, wr_addr, rd_addr_a, rd_addr_b, obs, expv);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k < 32; k++) model[k] = 32'(k * 7 + 1);
    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 5'(k), 32'(k * 7 + 1), 5'd0, 5'd0); step();
    end
    drive(1'b1, 5'd12, 32'hDEAD_BEEF, 5'd12, 5'd30);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = exp_all();
    if (obs !== expv) begin n_err++; $display("FAIL pre_reset got=%h want=%h", obs, expv); end
    rst_n = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    for (int k = 0; k < 32; k++) begin
      rd_addr_a = 5'(k); rd_addr_b = 5'(31 - k);
      #0.05;
      n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
      if (obs !== expv) begin n_err++; $display("FAIL async_reset idx=%0d got=%h want=%h", k, obs, expv); end
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd30);
    n_cmp++; obs = {a_byp, b_byp, a_nob, b_nob}; expv = 128'd0;
    if (obs !== expv) begin n_err++; $display("FAIL reset_wins got=%h want=%h", obs, expv); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    #1;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_fill_isolation();
    for (int k = 1; k < 32; k++) model[k] = 32'(k * 3);
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Write side: a 5-to-32 one-hot decoder routes write-back data into exactly one register. This is the demultiplexing counterpart of the 2:1 datapath muxes that select the write-back value.
- Two asynchronous read ports feed the ALU operand path.
- Register $zero is hardwired to 0.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable (RegWrite)
- wr_addr  input  ADDR_W  destination register index
- wr_data  input  DATA_W  write-back data
- rd_addr_a  input  ADDR_W  read port A index (rs)
- rd_addr_b  input  ADDR_W  read port B index (rt)
- rd_data_a  output  DATA_W  read port A data
- rd_data_b  output  DATA_W  read port B data

Behaviour:
- Reset:
  - rst_n low clears registers 1..31 to 0 immediately, without waiting for clk.
  - rd_data_a and rd_data_b read 0 while reset is held.
  - Deassertion is synchronised externally; the block does not synchronise it.
- Write:
  - On posedge clk with rst_n high and we high, reg[wr_addr] <= wr_data.
  - Exactly one register is written per cycle, selected by a one-hot decode of wr_addr.
- Register 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, regardless of BYPASS, we or wr_data.
- Read latency:
  - Combinational (zero-cycle) from rd_addr_x to rd_data_x.
  - A completed write is visible to reads from the cycle after the clock edge.
- BYPASS=1:
  - If we=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data in the same cycle, before the edge.
  - Both ports may bypass at once.
- BYPASS=0:
  - rd_data_x shows the old value until the edge.
- Simultaneous events:
  - rd_addr_a==rd_addr_b returns identical data on both ports.
  - A write plus two reads in one cycle is legal.
- Reset mid-operation:
  - A reset asserted in the same cycle as we=1 wins; the register stays 0.
  - A write in progress when rst_n falls is lost.
- we=0: no register changes, whatever wr_addr and wr_data are.
- No handshake; the write is accepted unconditionally every cycle we=1.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W constants.
  - REG_ZERO=0, REG_SP=29, REG_RA=31 index constants.
  - reg_idx_t (ADDR_W-bit) and word_t (DATA_W-bit) typedefs.
- One sub-module, regfile_wr_decoder:
  - Pure combinational: we + wr_addr -> 32-bit one-hot write-enable vector.
  - Bit 0 is forced to 0.
  - Instantiated once.
- Read selection: 32:1 muxes built inline in mips_regfile.

Test Plan:
- Reset check: hold rst_n=0 and read all 32 indices -> every rd_data = 0. Then write 32'd1111 to reg 8 while rst_n=0 -> reg 8 still reads 0 after release.
- Basic write/read: we=1, wr_addr=8, wr_data=32'd1111, then wr_addr=9, wr_data=32'd9999. Read rd_addr_a=8, rd_addr_b=9 next cycle -> 1111 and 9999.
- Register zero: we=1, wr_addr=0, wr_data=32'hFFFF_FFFF, then read index 0 on both ports -> 0 with BYPASS=0 and with BYPASS=1.
- Bypass:
  - Preload reg 31 = 32'h0000_0004.
  - Same cycle: we=1, wr_addr=31, wr_data=32'h0040_0010, rd_addr_a=rd_addr_b=31.
  - BYPASS=1 -> both ports show 0x00400010 before the edge.
  - BYPASS=0 -> both ports show 0x00000004 before the edge and 0x00400010 after it.
- Write disable and one-hot isolation:
  - Write a distinct value k*3 to each reg k=1..31, then pulse we=0 with wr_addr=5, wr_data=0.
  - All 31 registers retain k*3; a sweep of both read ports confirms no aliasing.
- Async reset mid-run: after the fills above, drop rst_n between clock edges -> all reads go to 0 immediately, before the next posedge.
